// File: rtl/wb_debug_arbiter_pkg.sv
// Shared definitions for the Wishbone debug-register arbiter.
//   arb_state_e      : arbiter FSM encoding (idle / m0 granted / m1 granted)
//   DBG_TIMEOUT_DATA : read data returned to a master whose access timed out
package wb_debug_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } arb_state_e;

    localparam logic [31:0] DBG_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_dbg_timeout.sv
// Bus-timeout watchdog for the debug arbiter.
// Counts cycles in which the granted strobe is waiting for an ack. On the
// TIMEOUT_CYCLES-th unanswered cycle it raises fire_o for one cycle and sets a
// sticky flag that only reset clears.
// Ports:
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   stb_i              : strobe of the granted master (before any forcing)
//   ack_i              : slave ack
//   idle_i             : arbiter is idle (clears the counter)
//   fire_o             : timeout occurs this cycle
//   timeout_o          : sticky timeout flag
module wb_dbg_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic stb_i,
    input  logic ack_i,
    input  logic idle_i,
    output logic fire_o,
    output logic timeout_o
);

    logic [TO_W-1:0] to_cnt_q;
    logic            flag_q;

    // A real ack in the same cycle always beats the timeout.
    assign fire_o    = stb_i & ~ack_i & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_o = flag_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            if (idle_i || ack_i || fire_o) begin
                to_cnt_q <= '0;
            end else if (stb_i) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (fire_o) begin
                flag_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_debug_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the debug register slave.
// m0 = management SoC bus, m1 = user-side debug master. A grant is held for the
// whole cyc burst; an idle cycle always separates two grants.
// Ports:
//   wb_clk_i, wb_rst_i        : clock, asynchronous active-high reset
//   m0_* / m1_*               : master-side Wishbone (cyc, stb, we, sel, adr, dat in; ack, dat out)
//   s_*                       : slave-side Wishbone (cyc, stb, we, sel, adr, dat out; ack, dat in)
//   timeout_o                 : sticky bus-timeout flag
// Build option: define WB_DBG_TIMEOUT_EN to enable the bus-timeout watchdog
// (TIMEOUT_CYCLES unanswered strobe cycles). Without it timeout_o is 0 and the
// arbiter waits for s_ack_i indefinitely.
module wb_debug_arbiter
    import wb_debug_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic        timeout_o
);

    arb_state_e  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        req0, req1;
    logic        grant0, grant1;
    logic        to_fire;
    logic        mux_cyc, mux_stb;
    logic        ack_int;
    logic [31:0] dat_int;

    assign req0   = m0_cyc_i & m0_stb_i;
    assign req1   = m1_cyc_i & m1_stb_i;
    assign grant0 = (state_q == StGrant0);
    assign grant1 = (state_q == StGrant1);

`ifdef WB_DBG_TIMEOUT_EN
    wb_dbg_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .stb_i     (mux_stb),
        .ack_i     (s_ack_i),
        .idle_i    (state_q == StIdle),
        .fire_o    (to_fire),
        .timeout_o (timeout_o)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, TO_W};
    assign to_fire    = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1; // so m0 wins the first tie
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (req0 && (!req1 || last_grant_q)) begin
                    state_d      = StGrant0;
                    last_grant_d = 1'b0;
                end else if (req1) begin
                    state_d      = StGrant1;
                    last_grant_d = 1'b1;
                end
            end
            StGrant0: if (!m0_cyc_i || to_fire) state_d = StIdle;
            StGrant1: if (!m1_cyc_i || to_fire) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Slave-side mux; everything is 0 while idle.
    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (grant0) begin
            mux_cyc = m0_cyc_i;
            mux_stb = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (grant1) begin
            mux_cyc = m1_cyc_i;
            mux_stb = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // A timeout withdraws the cycle from the slave and fakes the ack upstream.
    assign s_cyc_o  = mux_cyc & ~to_fire;
    assign s_stb_o  = mux_stb & ~to_fire;
    assign ack_int  = s_ack_i | to_fire;
    assign dat_int  = to_fire ? DBG_TIMEOUT_DATA : s_dat_i;

    assign m0_ack_o = grant0 & ack_int;
    assign m0_dat_o = grant0 ? dat_int : '0;
    assign m1_ack_o = grant1 & ack_int;
    assign m1_dat_o = grant1 ? dat_int : '0;

endmodule
